// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU opcodes, result-slot state and opcode class helpers
package alu_pkg;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b1000;
    localparam logic [3:0] OP_SLT  = 4'b0010;
    localparam logic [3:0] OP_SLTU = 4'b0011;
    localparam logic [3:0] OP_AND  = 4'b0111;
    localparam logic [3:0] OP_OR   = 4'b0110;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_SLL  = 4'b0001;
    localparam logic [3:0] OP_SRL  = 4'b0101;
    localparam logic [3:0] OP_SRA  = 4'b1101;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_t;

    function automatic logic is_shift(input logic [3:0] op);
        return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
    endfunction

    function automatic logic is_set(input logic [3:0] op);
        return (op == OP_SLT) || (op == OP_SLTU);
    endfunction

endpackage

// File: rtl/alu.sv
// rtl/alu.sv - 32-bit combinational integer ALU
module alu
    import alu_pkg::*;
(
    input  logic [31:0] op1,
    input  logic [31:0] op2,
    input  logic [3:0]  opcode,
    output logic [31:0] result
);

    // Pure combinational operation select; unknown opcodes yield zero.
    always_comb begin
        result = 32'd0;
        case (opcode)
            OP_ADD:  result = op1 + op2;
            OP_SUB:  result = op1 - op2;
            OP_SLT:  result = {31'd0, $signed(op1) < $signed(op2)};
            OP_SLTU: result = {31'd0, op1 < op2};
            OP_AND:  result = op1 & op2;
            OP_OR:   result = op1 | op2;
            OP_XOR:  result = op1 ^ op2;
            OP_SLL:  result = op1 << op2;
            OP_SRL:  result = op1 >> op2;
            OP_SRA:  result = $unsigned($signed(op1) >>> op2);
            default: result = 32'd0;
        endcase
    end

endmodule

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin pick with rotating priority pointer
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic               en,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_idx
);

    logic [ID_W-1:0] ptr;
    logic            found;
    int              cand;

    // Search upward from the pointer with wrap; the first active request wins.
    always_comb begin
        found     = 1'b0;
        grant_idx = '0;
        grant     = '0;
        cand      = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = int'(ptr) + k;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (!found && req[cand]) begin
                found     = 1'b1;
                grant_idx = ID_W'(cand);
            end
        end
        grant[grant_idx] = en && found;
    end

    // Advance priority past the winner only when a grant is actually issued.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (en && found) begin
            if (grant_idx == ID_W'(NUM_REQ - 1)) begin
                ptr <= '0;
            end else begin
                ptr <= grant_idx + 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - one shared ALU behind a round-robin arbiter and a result slot
module alu_share_arbiter
    import alu_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req_valid_in,
    output logic [NUM_REQ-1:0]   req_ready_out,
    input  logic [32*NUM_REQ-1:0] req_op1_in,
    input  logic [32*NUM_REQ-1:0] req_op2_in,
    input  logic [4*NUM_REQ-1:0] req_opcode_in,
    output logic                 rsp_valid_out,
    input  logic                 rsp_ready_in,
    output logic [31:0]          rsp_data_out,
    output logic [ID_W-1:0]      rsp_id_out
);

    slot_state_t     state_q, state_d;
    logic            can_accept;
    logic            xfer;
    logic [ID_W-1:0] win_idx;
    logic [31:0]     sel_op1, sel_op2, alu_op2, alu_res, fixed_res;
    logic [3:0]      sel_opc;

    // Gating with rst_n keeps every grant low while reset is held.
    assign can_accept = rst_n && ((state_q == SLOT_EMPTY) || rsp_ready_in);
    assign xfer       = |req_ready_out;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req_valid_in),
        .en        (can_accept),
        .grant     (req_ready_out),
        .grant_idx (win_idx)
    );

    // Route the winning requester's operand fields to the ALU.
    always_comb begin
        sel_op1 = '0;
        sel_op2 = '0;
        sel_opc = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_idx == ID_W'(i)) begin
                sel_op1 = req_op1_in[32*i +: 32];
                sel_op2 = req_op2_in[32*i +: 32];
                sel_opc = req_opcode_in[4*i +: 4];
            end
        end
    end

    // Shift amounts are 5 bits wide; set results collapse to a single bit.
    assign alu_op2   = is_shift(sel_opc) ? {27'd0, sel_op2[4:0]} : sel_op2;
    assign fixed_res = is_set(sel_opc) ? {31'd0, alu_res[0]} : alu_res;

    alu u_alu (
        .op1    (sel_op1),
        .op2    (alu_op2),
        .opcode (sel_opc),
        .result (alu_res)
    );

    // Slot fills on any transfer (including pop-and-load) and drains on a bare pop.
    always_comb begin
        state_d = state_q;
        if (xfer) begin
            state_d = SLOT_FULL;
        end else if ((state_q == SLOT_FULL) && rsp_ready_in) begin
            state_d = SLOT_EMPTY;
        end
    end

    // Slot state and payload; payload only changes on a transfer so it holds under backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= SLOT_EMPTY;
            rsp_data_out <= '0;
            rsp_id_out   <= '0;
        end else begin
            state_q <= state_d;
            if (xfer) begin
                rsp_data_out <= fixed_res;
                rsp_id_out   <= win_idx;
            end
        end
    end

    assign rsp_valid_out = (state_q == SLOT_FULL);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb/tb_alu_share_arbiter.sv - randomized and directed self-checking bench for alu_share_arbiter
module tb_alu_share_arbiter;

    localparam int N  = 2;
    localparam int IW = 1;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [32*N-1:0] op1, op2;
    logic [4*N-1:0]  opc;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [31:0]     rsp_data;
    logic [IW-1:0]   rsp_id;

    int vectors     = 0;
    int miscompares = 0;

    int          m_ptr;
    bit          m_full;
    logic [31:0] m_data;
    int          m_id;

    always #5 clk = ~clk;

    alu_share_arbiter #(.NUM_REQ(N), .ID_W(IW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid_in  (req_valid),
        .req_ready_out (req_ready),
        .req_op1_in    (op1),
        .req_op2_in    (op2),
        .req_opcode_in (opc),
        .rsp_valid_out (rsp_valid),
        .rsp_ready_in  (rsp_ready),
        .rsp_data_out  (rsp_data),
        .rsp_id_out    (rsp_id)
    );

    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int sh;
        sh = int'(b[4:0]);
        case (op)
            4'b0000: return a + b;
            4'b1000: return a - b;
            4'b0010: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'b0011: return (a < b) ? 32'd1 : 32'd0;
            4'b0111: return a & b;
            4'b0110: return a | b;
            4'b0100: return a ^ b;
            4'b0001: return a << sh;
            4'b0101: return a >> sh;
            4'b1101: return $unsigned($signed(a) >>> sh);
            default: return 32'd0;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ptr  = 0;
        m_full = 0;
        m_data = 0;
        m_id   = 0;
    endtask

    // Drive one cycle (called just after a falling edge), compare outputs against the model, advance the model.
    task automatic step(input logic [N-1:0] v, input logic [32*N-1:0] a, input logic [32*N-1:0] b,
                        input logic [4*N-1:0] o, input logic rdy, output int win);
        logic [N-1:0] exp_ready;
        bit can;
        int c;
        req_valid = v;
        op1       = a;
        op2       = b;
        opc       = o;
        rsp_ready = rdy;
        #1;
        can       = !m_full || rdy;
        win       = -1;
        exp_ready = '0;
        if (can) begin
            for (int k = 0; k < N; k++) begin
                c = (m_ptr + k) % N;
                if (win < 0 && v[c]) win = c;
            end
        end
        if (win >= 0) exp_ready[win] = 1'b1;
        check("req_ready", 32'(req_ready), 32'(exp_ready));
        check("rsp_valid", 32'(rsp_valid), 32'(m_full));
        if (m_full) begin
            check("rsp_data", rsp_data, m_data);
            check("rsp_id", 32'(rsp_id), 32'(m_id));
        end
        if (win >= 0) begin
            m_full = 1;
            m_data = ref_alu(o[4*win +: 4], a[32*win +: 32], b[32*win +: 32]);
            m_id   = win;
            m_ptr  = (win + 1) % N;
        end else if (m_full && rdy) begin
            m_full = 0;
        end
        @(negedge clk);
    endtask

    function automatic logic [63:0] pk(input logic [31:0] r0, input logic [31:0] r1);
        return {r1, r0};
    endfunction

    initial begin
        int w;
        logic [3:0]  t_op [6];
        logic [31:0] t_a [6];
        logic [31:0] t_b [6];
        logic [31:0] t_r [6];
        logic [3:0]  ro0, ro1;

        t_op = '{4'b0001, 4'b1101, 4'b0101, 4'b0010, 4'b0011, 4'b1111};
        t_a  = '{32'h1, 32'h80000000, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h12345678};
        t_b  = '{32'h21, 32'h4, 32'h4, 32'h1, 32'h1, 32'h9};
        t_r  = '{32'h2, 32'hF8000000, 32'h08000000, 32'h1, 32'h0, 32'h0};

        rst_n     = 1'b0;
        req_valid = '1;
        op1       = '0;
        op2       = '0;
        opc       = '0;
        rsp_ready = 1'b1;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check("reset_valid", 32'(rsp_valid), 32'd0);
        check("reset_data", rsp_data, 32'd0);
        check("reset_id", 32'(rsp_id), 32'd0);
        check("reset_ready", 32'(req_ready), 32'd0);
        rst_n = 1'b1;

        // Round robin from reset, ADD 5+7 on req0
        step(2'b11, pk(32'd5, 32'd9), pk(32'd7, 32'd1), 8'h60, 1'b1, w);
        check("first_grant", 32'(w), 32'd0);
        check("add_result", rsp_data, 32'd12);
        check("add_id", 32'(rsp_id), 32'd0);
        for (int i = 0; i < 4; i++) begin
            step(2'b11, pk(32'd5, 32'd9), pk(32'd7, 32'd1), 8'h60, 1'b1, w);
            check("rr_alternate", 32'(w), (i % 2 == 0) ? 32'd1 : 32'd0);
            check("rr_id_lag", 32'(rsp_id), 32'(w));
        end

        // Asynchronous reset while a result is pending
        check("pre_reset_valid", 32'(rsp_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async_valid", 32'(rsp_valid), 32'd0);
        check("async_data", rsp_data, 32'd0);
        check("async_ready", 32'(req_ready), 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step(2'b11, pk(32'd1, 32'd2), pk(32'd3, 32'd4), 8'h00, 1'b1, w);
        check("grant_after_reset", 32'(w), 32'd0);

        // Backpressure holding SUB 3-5
        step(2'b01, pk(32'd3, 32'd0), pk(32'd5, 32'd0), 8'h08, 1'b1, w);
        check("sub_result", rsp_data, 32'hFFFFFFFE);
        for (int i = 0; i < 3; i++) begin
            step(2'b11, pk(32'd10, 32'd20), pk(32'd1, 32'd2), 8'h00, 1'b0, w);
            check("bp_no_grant", 32'(w), 32'hFFFFFFFF);
            check("bp_hold_data", rsp_data, 32'hFFFFFFFE);
            check("bp_hold_id", 32'(rsp_id), 32'd0);
        end
        step(2'b11, pk(32'd10, 32'd20), pk(32'd1, 32'd2), 8'h00, 1'b1, w);
        check("bp_release_grant", 32'(w), 32'd1);
        check("bp_new_data", rsp_data, 32'd22);

        // Shift masking, set normalisation, unlisted opcode
        for (int i = 0; i < 6; i++) begin
            step(2'b01, pk(t_a[i], 32'd0), pk(t_b[i], 32'd0), {4'b0000, t_op[i]}, 1'b1, w);
            check("fixup_result", rsp_data, t_r[i]);
            check("fixup_valid", 32'(rsp_valid), 32'd1);
        end

        // Single requester, then idle
        for (int i = 0; i < 4; i++) begin
            step(2'b10, pk(32'd0, 32'(i)), pk(32'd0, 32'd100), 8'h00, 1'b1, w);
            check("single_grant", 32'(w), 32'd1);
            check("single_data", rsp_data, 32'(100 + i));
        end
        step(2'b00, '0, '0, '0, 1'b1, w);
        step(2'b00, '0, '0, '0, 1'b1, w);
        check("idle_empty", 32'(rsp_valid), 32'd0);
        step(2'b11, '0, '0, '0, 1'b1, w);
        check("ptr_held_at_0", 32'(w), 32'd0);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            ro0 = 4'($urandom_range(0, 15));
            ro1 = 4'($urandom_range(0, 15));
            step(2'($urandom), pk($urandom, ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom),
                 pk(($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom, $urandom),
                 {ro1, ro0}, ($urandom_range(0, 9) < 7), w);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
